// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler sharing one countdown timer among
// N_REQ requesters. The granted requester's duration is loaded at grant,
// counted down (with pause/abort/voluntary release), and a one-cycle trigger
// pulse is returned to the owner on expiry.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   req       per-requester request level, held until trigger or release
//   duration  packed durations, slice i = duration[i*CNT_W +: CNT_W]
//   pause     freeze the running count (level)
//   abort     cancel current timing without trigger
//   grant     one-hot owner, zero when idle
//   trigger   one-cycle expiry pulse to the owner
//   busy      high in COUNTING, PAUSED or DONE
//   count     remaining count
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no owner; pick next requester round-robin from last+1
// COUNTING | owner holds the timer, count decrements each cycle
// PAUSED   | owner holds the timer, count frozen
// DONE     | trigger/grant high for one cycle, then back to IDLE

module timer_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] duration,
  input  logic                   pause,
  input  logic                   abort,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       trigger,
  output logic                   busy,
  output logic [CNT_W-1:0]       count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    PAUSED   = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] owner;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic [N_REQ-1:0] win_onehot;
  logic [CNT_W-1:0] win_dur;

  // Round-robin search: first set req bit starting at last+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign win_dur = duration[int'(win_idx)*CNT_W +: CNT_W];

  // Owner's own request going low counts as a voluntary release.
  logic owner_release;
  assign owner_release = abort || !req[owner];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      trigger <= '0;
      busy    <= 1'b0;
      count   <= '0;
      last    <= IDX_W'(N_REQ - 1);
      owner   <= '0;
    end else begin
      case (state)
        IDLE: begin
          trigger <= '0;
          if (win_found) begin
            grant <= win_onehot;
            last  <= win_idx;
            owner <= win_idx;
            count <= win_dur;
            busy  <= 1'b1;
            if (win_dur == '0) begin
              // Zero duration expires immediately: grant and trigger together.
              state   <= DONE;
              trigger <= win_onehot;
            end else begin
              state <= COUNTING;
            end
          end
        end

        COUNTING: begin
          if (owner_release) begin
            state <= IDLE;
            grant <= '0;
            count <= '0;
            busy  <= 1'b0;
          end else if (pause) begin
            state <= PAUSED;
          end else if (count <= CNT_W'(1)) begin
            // Expiry; decrement only ever happens from values >= 2.
            state   <= DONE;
            count   <= '0;
            trigger <= grant;
          end else begin
            count <= count - CNT_W'(1);
          end
        end

        PAUSED: begin
          if (owner_release) begin
            state <= IDLE;
            grant <= '0;
            count <= '0;
            busy  <= 1'b0;
          end else if (!pause) begin
            // Resume edge does not decrement.
            state <= COUNTING;
          end
        end

        DONE: begin
          state   <= IDLE;
          grant   <= '0;
          trigger <= '0;
          busy    <= 1'b0;
          count   <= '0;
        end

        default: begin
          state   <= IDLE;
          grant   <= '0;
          trigger <= '0;
          busy    <= 1'b0;
          count   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
module tb_timer_sched;

  localparam int N_REQ = 4;
  localparam int CNT_W = 16;

  logic                   clk;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] duration;
  logic                   pause;
  logic                   abort;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       trigger;
  logic                   busy;
  logic [CNT_W-1:0]       count;

  int n_total = 0;
  int n_pass  = 0;

  timer_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .duration (duration),
    .pause    (pause),
    .abort    (abort),
    .grant    (grant),
    .trigger  (trigger),
    .busy     (busy),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int idx, input logic [CNT_W-1:0] d);
    duration[idx*CNT_W +: CNT_W] = d;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; duration = '0; pause = 1'b0; abort = 1'b0;
    step(2);
    n_total++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); else n_pass++;
    n_total++; if (trigger !== 4'b0000) $display("FAIL reset_trigger: got %b expected %b", trigger, 4'b0000); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); else n_pass++;
    n_total++; if (count !== 16'd0) $display("FAIL reset_count: got %0d expected %0d", count, 0); else n_pass++;
    reset = 1'b0;
    step(1);
    n_total++; if (grant !== 4'b0000) $display("FAIL idle_grant: got %b expected %b", grant, 4'b0000); else n_pass++;
  endtask

  task automatic test_single;
    set_dur(0, 16'd5);
    req = 4'b0001;
    step(1);
    n_total++; if (grant !== 4'b0001) $display("FAIL single_grant: got %b expected %b", grant, 4'b0001); else n_pass++;
    n_total++; if (count !== 16'd5) $display("FAIL single_load: got %0d expected %0d", count, 5); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected %b", busy, 1'b1); else n_pass++;
    for (int i = 4; i >= 1; i--) begin
      step(1);
      n_total++; if (count !== 16'(i)) $display("FAIL single_count: got %0d expected %0d", count, i); else n_pass++;
      n_total++; if (trigger !== 4'b0000) $display("FAIL single_early_trig: got %b expected %b", trigger, 4'b0000); else n_pass++;
    end
    step(1);
    n_total++; if (trigger !== 4'b0001) $display("FAIL single_trigger: got %b expected %b", trigger, 4'b0001); else n_pass++;
    n_total++; if (grant !== 4'b0001) $display("FAIL single_grant_done: got %b expected %b", grant, 4'b0001); else n_pass++;
    n_total++; if (count !== 16'd0) $display("FAIL single_count_done: got %0d expected %0d", count, 0); else n_pass++;
    req = 4'b0000;
    step(1);
    n_total++; if (grant !== 4'b0000) $display("FAIL single_release: got %b expected %b", grant, 4'b0000); else n_pass++;
    n_total++; if (trigger !== 4'b0000) $display("FAIL single_trig_off: got %b expected %b", trigger, 4'b0000); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_off: got %b expected %b", busy, 1'b0); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_dur(i, 16'd2);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      step(1);
      n_total++; if (grant !== exp) $display("FAIL rr_grant%0d: got %b expected %b", g, grant, exp); else n_pass++;
      n_total++; if (count !== 16'd2) $display("FAIL rr_load%0d: got %0d expected %0d", g, count, 2); else n_pass++;
      step(1);
      n_total++; if (trigger !== 4'b0000) $display("FAIL rr_early%0d: got %b expected %b", g, trigger, 4'b0000); else n_pass++;
      step(1);
      n_total++; if (trigger !== exp) $display("FAIL rr_trig%0d: got %b expected %b", g, trigger, exp); else n_pass++;
      step(1);
      n_total++; if (grant !== 4'b0000) $display("FAIL rr_gap%0d: got %b expected %b", g, grant, 4'b0000); else n_pass++;
      if (g == 4) req = 4'b0000;
    end
    step(1);
    n_total++; if (grant !== 4'b0000) $display("FAIL rr_end: got %b expected %b", grant, 4'b0000); else n_pass++;
  endtask

  // last = 0 here, so requester 1 wins.
  task automatic test_pause;
    set_dur(1, 16'd10);
    req = 4'b0010;
    step(1);
    n_total++; if (grant !== 4'b0010) $display("FAIL pause_grant: got %b expected %b", grant, 4'b0010); else n_pass++;
    step(4);
    n_total++; if (count !== 16'd6) $display("FAIL pause_pre: got %0d expected %0d", count, 6); else n_pass++;
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_total++; if (count !== 16'd6) $display("FAIL pause_hold%0d: got %0d expected %0d", i, count, 6); else n_pass++;
    end
    n_total++; if (busy !== 1'b1) $display("FAIL pause_busy: got %b expected %b", busy, 1'b1); else n_pass++;
    pause = 1'b0;
    step(1);
    n_total++; if (count !== 16'd6) $display("FAIL pause_resume: got %0d expected %0d", count, 6); else n_pass++;
    step(5);
    n_total++; if (count !== 16'd1) $display("FAIL pause_last: got %0d expected %0d", count, 1); else n_pass++;
    n_total++; if (trigger !== 4'b0000) $display("FAIL pause_early: got %b expected %b", trigger, 4'b0000); else n_pass++;
    step(1);
    n_total++; if (trigger !== 4'b0010) $display("FAIL pause_trig: got %b expected %b", trigger, 4'b0010); else n_pass++;
    req = 4'b0000;
    step(1);
    n_total++; if (grant !== 4'b0000) $display("FAIL pause_end: got %b expected %b", grant, 4'b0000); else n_pass++;
  endtask

  // last = 1 here, so requester 2 wins, then pending requester 3.
  task automatic test_abort;
    set_dur(2, 16'd8);
    set_dur(3, 16'd7);
    req = 4'b0100;
    step(1);
    n_total++; if (grant !== 4'b0100) $display("FAIL abort_grant: got %b expected %b", grant, 4'b0100); else n_pass++;
    step(4);
    n_total++; if (count !== 16'd4) $display("FAIL abort_pre: got %0d expected %0d", count, 4); else n_pass++;
    abort = 1'b1;
    req = 4'b1100;
    step(1);
    abort = 1'b0;
    n_total++; if (grant !== 4'b0000) $display("FAIL abort_grant_off: got %b expected %b", grant, 4'b0000); else n_pass++;
    n_total++; if (count !== 16'd0) $display("FAIL abort_count: got %0d expected %0d", count, 0); else n_pass++;
    n_total++; if (trigger !== 4'b0000) $display("FAIL abort_trig: got %b expected %b", trigger, 4'b0000); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected %b", busy, 1'b0); else n_pass++;
    req = 4'b1000;
    step(1);
    n_total++; if (grant !== 4'b1000) $display("FAIL abort_next: got %b expected %b", grant, 4'b1000); else n_pass++;
    n_total++; if (count !== 16'd7) $display("FAIL abort_next_load: got %0d expected %0d", count, 7); else n_pass++;
    req = 4'b0000;
    step(1);
    n_total++; if (grant !== 4'b0000) $display("FAIL abort_next_rel: got %b expected %b", grant, 4'b0000); else n_pass++;
  endtask

  // last = 3 here.
  task automatic test_zero_and_release;
    set_dur(2, 16'd0);
    set_dur(1, 16'd6);
    req = 4'b0100;
    step(1);
    n_total++; if (grant !== 4'b0100) $display("FAIL zero_grant: got %b expected %b", grant, 4'b0100); else n_pass++;
    n_total++; if (trigger !== 4'b0100) $display("FAIL zero_trig: got %b expected %b", trigger, 4'b0100); else n_pass++;
    n_total++; if (count !== 16'd0) $display("FAIL zero_count: got %0d expected %0d", count, 0); else n_pass++;
    req = 4'b0000;
    step(1);
    n_total++; if (trigger !== 4'b0000) $display("FAIL zero_trig_off: got %b expected %b", trigger, 4'b0000); else n_pass++;
    n_total++; if (grant !== 4'b0000) $display("FAIL zero_grant_off: got %b expected %b", grant, 4'b0000); else n_pass++;
    req = 4'b0010;
    step(1);
    n_total++; if (grant !== 4'b0010) $display("FAIL rel_grant: got %b expected %b", grant, 4'b0010); else n_pass++;
    step(2);
    n_total++; if (count !== 16'd4) $display("FAIL rel_count: got %0d expected %0d", count, 4); else n_pass++;
    req = 4'b0000;
    step(1);
    n_total++; if (grant !== 4'b0000) $display("FAIL rel_grant_off: got %b expected %b", grant, 4'b0000); else n_pass++;
    n_total++; if (count !== 16'd0) $display("FAIL rel_count_off: got %0d expected %0d", count, 0); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (trigger !== 4'b0000) $display("FAIL rel_no_trig%0d: got %b expected %b", i, trigger, 4'b0000); else n_pass++;
      step(1);
    end
  endtask

  // last = 1 here, so requester 0 wins (search 2,3,0).
  task automatic test_coincidence;
    set_dur(0, 16'd2);
    req = 4'b0001;
    step(1);
    n_total++; if (grant !== 4'b0001) $display("FAIL coin_grant: got %b expected %b", grant, 4'b0001); else n_pass++;
    step(1);
    n_total++; if (count !== 16'd1) $display("FAIL coin_one: got %0d expected %0d", count, 1); else n_pass++;
    pause = 1'b1;
    step(2);
    n_total++; if (count !== 16'd1) $display("FAIL coin_pause_hold: got %0d expected %0d", count, 1); else n_pass++;
    n_total++; if (trigger !== 4'b0000) $display("FAIL coin_pause_trig: got %b expected %b", trigger, 4'b0000); else n_pass++;
    abort = 1'b1;
    step(1);
    abort = 1'b0; pause = 1'b0; req = 4'b0000;
    n_total++; if (grant !== 4'b0000) $display("FAIL coin_abort: got %b expected %b", grant, 4'b0000); else n_pass++;
    n_total++; if (trigger !== 4'b0000) $display("FAIL coin_abort_trig: got %b expected %b", trigger, 4'b0000); else n_pass++;
    step(1);
  endtask

  // last = 0 here, so requester 0 is only reached through wrap (search 1,2,3,0).
  task automatic test_reset_paused;
    set_dur(0, 16'd5);
    req = 4'b0001;
    step(1);
    n_total++; if (grant !== 4'b0001) $display("FAIL rp_grant: got %b expected %b", grant, 4'b0001); else n_pass++;
    step(2);
    n_total++; if (count !== 16'd3) $display("FAIL rp_count: got %0d expected %0d", count, 3); else n_pass++;
    pause = 1'b1;
    step(1);
    n_total++; if (count !== 16'd3) $display("FAIL rp_paused: got %0d expected %0d", count, 3); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (grant !== 4'b0000) $display("FAIL rp_async_grant: got %b expected %b", grant, 4'b0000); else n_pass++;
    n_total++; if (count !== 16'd0) $display("FAIL rp_async_count: got %0d expected %0d", count, 0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rp_async_busy: got %b expected %b", busy, 1'b0); else n_pass++;
    n_total++; if (trigger !== 4'b0000) $display("FAIL rp_async_trig: got %b expected %b", trigger, 4'b0000); else n_pass++;
    reset = 1'b0;
    pause = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_dur(i, 16'd3);
    req = 4'b1111;
    step(1);
    n_total++; if (grant !== 4'b0001) $display("FAIL rp_after_grant: got %b expected %b", grant, 4'b0001); else n_pass++;
    n_total++; if (count !== 16'd3) $display("FAIL rp_after_load: got %0d expected %0d", count, 3); else n_pass++;
    req = 4'b0000;
    step(1);
    n_total++; if (grant !== 4'b0000) $display("FAIL rp_end: got %b expected %b", grant, 4'b0000); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_pause;
    test_abort;
    test_zero_and_release;
    test_coincidence;
    test_reset_paused;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
# timer_sched

Round-robin scheduler that shares one countdown timer between `N_REQ` requesters. A requester raises `req` with a duration. The block grants the timer to one requester and counts the duration down. While counting it honours pause and abort, then pulses `trigger` back to the owner. It wraps the idle/counting/paused/done timer behaviour so that several datapath blocks can use one timing resource.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `CNT_W`, 16: duration/count width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  N_REQ  request per requester; level, held until trigger or voluntary release.
- `duration`  in  N_REQ*CNT_W  packed durations; slice i = `duration[i*CNT_W +: CNT_W]`, sampled only at grant.
- `pause`  in  1  freeze the running count (level).
- `abort`  in  1  cancel the current timing, no trigger.
- `grant`  out  N_REQ  one-hot owner, zero when idle.
- `trigger`  out  N_REQ  one-cycle expiry pulse to the owner.
- `busy`  out  1  high in COUNTING, PAUSED or DONE.
- `count`  out  CNT_W  remaining count.

## Operation
- All outputs are registered. Reset values:
  - state IDLE, `grant`=0, `trigger`=0, `busy`=0, `count`=0.
  - Round-robin pointer `last`=N_REQ-1, so requester 0 has first priority.
- States: IDLE, COUNTING, PAUSED, DONE.
- IDLE behaviour:
  - `pause` and `abort` are ignored.
  - If any `req` bit is set, the winner is the first set bit searching upward from `last+1`, wrapping modulo N_REQ.
  - At the edge: `grant[w]`=1, `last`=w, `count`=`duration[w]`.
  - Next state is COUNTING, or DONE if the duration is 0.
- COUNTING, priority per edge (highest first):
  1. `abort` → IDLE, grant cleared, `count`=0, no trigger.
  2. Owner's `req` low → IDLE, same as abort (voluntary release).
  3. `pause` → PAUSED, count held.
  4. `count`==1 → DONE, `count`=0.
  5. Otherwise `count`=`count`-1.
- PAUSED:
  - `abort` or owner `req` low → IDLE, no trigger.
  - `pause` low → COUNTING, no decrement on that edge.
  - Otherwise count is held.
- DONE:
  - `trigger[owner]`=1 and `grant[owner]`=1 for exactly one cycle.
  - Next edge → IDLE, grant cleared. `abort`, `pause` and `req` are ignored in DONE.
- `count` never underflows. Arithmetic is unsigned CNT_W, and the decrement only occurs from values ≥2.
- Requests from non-owners are ignored until IDLE. `req` changes from non-owners never affect the current owner.
- `trigger` and `grant` are always zero or a subset of the same single bit.

## Timing
- Grant latency: a `req` sampled high in IDLE at edge k gives `grant` high after edge k.
- Expiry for duration D≥1 with no pause:
  - COUNTING is entered at edge k, DONE at edge k+D.
  - `trigger` is high in the cycle following edge k+D, i.e. D cycles after grant first rose.
- Expiry for D=0: `grant` and `trigger` rise together after edge k, for one cycle.
- Each cycle spent in PAUSED delays the trigger by one cycle, plus one cycle per resume (no decrement on the resume edge).
- Back-to-back: the trigger cycle is followed by one IDLE cycle, then the next grant. The minimum gap between triggers is D+2 cycles.
- Edge coincidences:
  - `pause` on the same edge as `count`==1: pause wins, count stays 1.
  - `abort` with `pause`: abort wins.
- Reset asserted mid-operation:
  - Outputs return to reset values asynchronously, with no trigger.
  - `last` resets to N_REQ-1.

## Test plan
- Reset, then `req`=0001 with D=5 → `grant`=0001 after one edge; `count` 5,4,3,2,1; `trigger`=0001 for one cycle 5 cycles after grant; `grant`=0 next cycle.
- `req`=1111 held, all D=2 → grants 0001, 0010, 0100, 1000, 0001 in order; each trigger is 2 cycles after its grant; grants are 4 cycles apart.
- D=10, `pause` high for 3 cycles at `count`=6 → count holds 6; the trigger arrives 14 cycles after grant (10 + 3 paused + 1 resume).
- D=8, `abort` pulse at `count`=4 → IDLE next edge, `grant`=0, `count`=0, no trigger; a pending `req` on another bit is granted the following edge.
- D=0 on requester 2 → `grant`=0100 and `trigger`=0100 in the same single cycle; requester 1 dropping `req` mid-count (D=6) → release with no trigger.
- Async `reset` pulse while PAUSED at `count`=3 → all outputs 0 without a clock edge; after release, requester 0 wins when all requesters are requesting.
